sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Purpose: two-port round-robin arbiter in front of one single-port SRAM with registered read data.
// Latency: the SRAM command is issued one edge after accept, and read data is valid two edges after accept.
// Backpressure: at most one req_ready per cycle; responses are never stalled.
module sram_arbiter #(
    parameter int ADR  = 16,
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid_0,
    input  logic            req_we_0,
    input  logic [ADR-1:0]  req_adr_0,
    input  logic [BITS-1:0] req_wdata_0,
    output logic            req_ready_0,

    input  logic            req_valid_1,
    input  logic            req_we_1,
    input  logic [ADR-1:0]  req_adr_1,
    input  logic [BITS-1:0] req_wdata_1,
    output logic            req_ready_1,

    output logic            rsp_valid_0,
    output logic [BITS-1:0] rsp_rdata_0,
    output logic            rsp_valid_1,
    output logic [BITS-1:0] rsp_rdata_1,

    output logic [ADR-1:0]  mem_adr,
    output logic [BITS-1:0] mem_in,
    output logic            mem_we,
    output logic            mem_oe,
    input  logic [BITS-1:0] mem_out
);

    // last_grant = 1 means port 1 won the most recent accepted transfer.
    logic            last_grant;
    logic            gnt_0;
    logic            gnt_1;
    logic            accept;
    logic            winner;
    logic            sel_we;
    logic [ADR-1:0]  sel_adr;
    logic [BITS-1:0] sel_wdata;

    logic            s1_rd;
    logic            s1_port;
    logic            s2_rd;
    logic            s2_port;

    // Grant is purely combinational so a lone requester never sees an idle bubble.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (!rst) begin
            if (req_valid_0 && req_valid_1) begin
                gnt_0 = last_grant;
                gnt_1 = !last_grant;
            end else begin
                gnt_0 = req_valid_0;
                gnt_1 = req_valid_1;
            end
        end
    end

    assign req_ready_0 = gnt_0;
    assign req_ready_1 = gnt_1;

    // A grant is only ever given to a valid port, so any grant is an accept.
    assign accept = gnt_0 | gnt_1;
    assign winner = gnt_1;

    always_comb begin
        sel_we    = req_we_0;
        sel_adr   = req_adr_0;
        sel_wdata = req_wdata_0;
        if (winner) begin
            sel_we    = req_we_1;
            sel_adr   = req_adr_1;
            sel_wdata = req_wdata_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end

    // Stage 1 drives the SRAM pins directly. Address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_adr <= '0;
            mem_in  <= '0;
            mem_we  <= 1'b0;
            mem_oe  <= 1'b0;
            s1_rd   <= 1'b0;
            s1_port <= 1'b0;
        end else if (accept) begin
            mem_adr <= sel_adr;
            mem_in  <= sel_wdata;
            mem_we  <= sel_we;
            mem_oe  <= !sel_we;
            s1_rd   <= !sel_we;
            s1_port <= winner;
        end else begin
            mem_we  <= 1'b0;
            mem_oe  <= 1'b0;
            s1_rd   <= 1'b0;
        end
    end

    // Stage 2 lines up with the SRAM's registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rd   <= 1'b0;
            s2_port <= 1'b0;
        end else begin
            s2_rd   <= s1_rd;
            s2_port <= s1_port;
        end
    end

    assign rsp_valid_0 = s2_rd & !s2_port;
    assign rsp_valid_1 = s2_rd &  s2_port;
    assign rsp_rdata_0 = mem_out;
    assign rsp_rdata_1 = mem_out;

    a_one_grant: assert property (@(posedge clk) !(req_ready_0 && req_ready_1));
    a_grant_valid: assert property (@(posedge clk)
        (!req_ready_0 || req_valid_0) && (!req_ready_1 || req_valid_1));
    a_one_rsp: assert property (@(posedge clk) !(rsp_valid_0 && rsp_valid_1));

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter. It uses a behavioural SRAM and a transaction-level reference model.
module tb_sram_arbiter;
    localparam int ADR  = 16;
    localparam int BITS = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid_0, req_we_0, req_ready_0;
    logic            req_valid_1, req_we_1, req_ready_1;
    logic [ADR-1:0]  req_adr_0, req_adr_1;
    logic [BITS-1:0] req_wdata_0, req_wdata_1;
    logic            rsp_valid_0, rsp_valid_1;
    logic [BITS-1:0] rsp_rdata_0, rsp_rdata_1;
    logic [ADR-1:0]  mem_adr;
    logic [BITS-1:0] mem_in, mem_out;
    logic            mem_we, mem_oe;

    always #5 clk = ~clk;

    sram_arbiter #(.ADR(ADR), .BITS(BITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_we_0(req_we_0), .req_adr_0(req_adr_0),
        .req_wdata_0(req_wdata_0), .req_ready_0(req_ready_0),
        .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_adr_1(req_adr_1),
        .req_wdata_1(req_wdata_1), .req_ready_1(req_ready_1),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .mem_adr(mem_adr), .mem_in(mem_in), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_out(mem_out)
    );

    function automatic logic [BITS-1:0] init_val(input logic [ADR-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Behavioural SRAM: the command is executed at the edge, and read data is registered.
    logic [BITS-1:0] sram    [256];
    logic            sram_wr [256];
    logic            sram_clr = 1'b1;
    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < 256; i++) sram_wr[i] <= 1'b0;
        end else if (mem_we) begin
            sram[mem_adr[7:0]]    <= mem_in;
            sram_wr[mem_adr[7:0]] <= 1'b1;
        end
        if (mem_oe) mem_out <= sram_wr[mem_adr[7:0]] ? sram[mem_adr[7:0]] : init_val(mem_adr);
    end

    typedef struct { logic we; logic [ADR-1:0] adr; logic [BITS-1:0] wdata; } req_t;
    typedef struct { int port; logic [BITS-1:0] data; int due; } exp_t;

    req_t            pq0[$], pq1[$];
    exp_t            sb[$];
    logic [BITS-1:0] ref_mem [int];
    int              n_cmp = 0, n_bad = 0, cyc = 0, density = 100, model_last = 1;
    bit              acc0 = 0, acc1 = 0, mon_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic req_t mk(input logic we, input logic [ADR-1:0] adr, input logic [BITS-1:0] d);
        req_t r;
        r.we = we; r.adr = adr; r.wdata = d;
        return r;
    endfunction

    function automatic logic [BITS-1:0] ref_rd(input logic [ADR-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor/scoreboard: checks grants, SRAM pins and responses against the transaction model.
    logic [ADR-1:0]  e_adr;
    logic [BITS-1:0] e_in;
    logic            e_we, e_oe;
    logic [1:0]      expg;
    int              p;
    req_t            r;
    exp_t            e, ne;
    always @(negedge clk) begin
        if (mon_on) begin
            check("mem_we", 64'(mem_we), 64'(e_we));
            check("mem_oe", 64'(mem_oe), 64'(e_oe));
            check("mem_adr", 64'(mem_adr), 64'(e_adr));
            check("mem_in", 64'(mem_in), 64'(e_in));
        end
        if (rsp_valid_0 || rsp_valid_1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got valid=%b%b, expected none (cycle %0d)",
                         rsp_valid_1, rsp_valid_0, cyc);
            end else begin
                e = sb.pop_front();
                check("rsp_port", 64'({rsp_valid_1, rsp_valid_0}), (e.port == 1) ? 64'd2 : 64'd1);
                check("rsp_cycle", 64'(cyc), 64'(e.due));
                check("rsp_rdata", 64'((e.port == 1) ? rsp_rdata_1 : rsp_rdata_0), 64'(e.data));
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_missing: got nothing, expected port %0d data %0h at cycle %0d",
                     sb[0].port, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end

        // Round-robin: a lone valid wins, and a tie goes to the port that did not win last time.
        if (rst) expg = 2'b00;
        else if (req_valid_0 && req_valid_1) expg = (model_last == 1) ? 2'b01 : 2'b10;
        else expg = {req_valid_1, req_valid_0};
        check("ready", 64'({req_ready_1, req_ready_0}), 64'(expg));

        p = -1;
        if (!rst && req_valid_0 && req_ready_0) p = 0;
        else if (!rst && req_valid_1 && req_ready_1) p = 1;
        e_we = 1'b0;
        e_oe = 1'b0;
        if (p >= 0) begin
            r = (p == 0) ? pq0[0] : pq1[0];
            if (r.we) begin
                ref_mem[int'(r.adr)] = r.wdata;
            end else begin
                ne.port = p; ne.data = ref_rd(r.adr); ne.due = cyc + 2;
                sb.push_back(ne);
            end
            model_last = p;
            if (p == 0) acc0 = 1; else acc1 = 1;
            e_we = r.we; e_oe = !r.we; e_adr = r.adr; e_in = r.wdata;
        end
        if (rst) begin
            e_adr = '0; e_in = '0; model_last = 1; mon_on = 1;
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (acc0) begin void'(pq0.pop_front()); req_valid_0 = 1'b0; acc0 = 0; end
        if (acc1) begin void'(pq1.pop_front()); req_valid_1 = 1'b0; acc1 = 0; end
        if (!req_valid_0 && pq0.size() > 0 && $urandom_range(99) < density) begin
            req_valid_0 = 1'b1; req_we_0 = pq0[0].we; req_adr_0 = pq0[0].adr; req_wdata_0 = pq0[0].wdata;
        end
        if (!req_valid_1 && pq1.size() > 0 && $urandom_range(99) < density) begin
            req_valid_1 = 1'b1; req_we_1 = pq1[0].we; req_adr_1 = pq1[0].adr; req_wdata_1 = pq1[0].wdata;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d/%0d/%0d left after %0d cycles, expected 0",
                     name, pq0.size(), pq1.size(), sb.size(), budget);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected one within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_0 = 0; req_we_0 = 0; req_adr_0 = '0; req_wdata_0 = '0;
        req_valid_1 = 0; req_we_1 = 0; req_adr_1 = '0; req_wdata_1 = '0;

        // Write then read back on port 0. Valid is held during reset, so ready must stay low.
        pq0.push_back(mk(1'b1, 16'h0010, 32'hDEADBEEF));
        pq0.push_back(mk(1'b0, 16'h0010, '0));
        step();
        sram_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        drain("wr_rd", 20);

        // Both ports continuously valid from reset: grants alternate 0,1,0,1...
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            pq0.push_back(mk(1'b0, 16'h0001, '0));
            pq1.push_back(mk(1'b0, 16'h0002, '0));
        end
        drain("rr", 40);

        // Port 1 alone issues back-to-back reads.
        for (int a = 3; a <= 6; a++) pq1.push_back(mk(1'b0, 16'(a), '0));
        drain("burst", 20);

        // Write on port 0, then a read of the same address on port 1 in the next cycle.
        pq0.push_back(mk(1'b1, 16'h0020, 32'h12345678));
        step();
        pq1.push_back(mk(1'b0, 16'h0020, '0));
        drain("raw", 20);

        // A read is in flight when reset hits: it must be dropped, and the next tie goes to port 0.
        pq0.push_back(mk(1'b0, 16'h0030, '0));
        step();
        step();
        rst = 1'b1;
        step();
        step();
        pq0.push_back(mk(1'b0, 16'h0005, '0));
        pq1.push_back(mk(1'b0, 16'h0006, '0));
        step();
        rst = 1'b0;
        drain("rst_flush", 20);

        // Idle: nothing should move.
        repeat (10) step();

        // Randomised traffic on a small address range, with varying request density.
        for (int ph = 0; ph < 4; ph++) begin
            density = (ph == 0) ? 30 : (ph == 1) ? 60 : (ph == 2) ? 90 : 100;
            for (int i = 0; i < 100; i++) begin
                r = mk(1'($urandom_range(1)), 16'($urandom_range(15)), $urandom);
                if ($urandom_range(1) == 0) pq0.push_back(r); else pq1.push_back(r);
            end
            if (ph == 2) begin
                repeat (15) step();
                rst = 1'b1;
                repeat (2) step();
                rst = 1'b0;
            end
            drain("random", 1000);
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
